// File: rtl/ibis_tmds_channel.sv
// ibis_tmds_channel
// One TMDS (DVI) lane: 8b/10b DC-balanced encoder feeding a 2-bit-per-clock
// rotating shifter for a 5:1 DDR serializer.
//
// Ports
//   aclk        link clock, 5x pixel rate
//   areset      asynchronous active-high reset
//   enable      global clock enable; low freezes every register
//   load        pixel-slot strobe (qualified by enable)
//   data_enable 1 = encode data, 0 = encode control {c1,c0}
//   c0, c1      control bits
//   data        pixel byte
//   symbol      last encoded 10-bit symbol (registered)
//   tmds_pair   current bit pair, [0] transmitted first
//   misalign    sticky: a symbol was loaded mid-rotation
module ibis_tmds_channel #(
   parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100
) (
   input  logic       aclk,
   input  logic       areset,
   input  logic       enable,
   input  logic       load,
   input  logic       data_enable,
   input  logic       c0,
   input  logic       c1,
   input  logic [7:0] data,
   output logic [9:0] symbol,
   output logic [1:0] tmds_pair,
   output logic       misalign
);

   // stage 1 registers
   logic       valid;
   logic       de_r;
   logic       c0_r;
   logic       c1_r;
   logic [8:0] q_m_r;

   // stage 2 / shifter state; cnt holds signed two's complement disparity
   logic [4:0] cnt;
   logic [9:0] shreg;
   logic [2:0] phase;
   logic       armed;

   logic [3:0] n1_d;
   logic       use_xnor;
   logic [8:0] q_m_d;

   logic [3:0] n1_q;
   logic [4:0] disp;
   logic [9:0] sym_nxt;
   logic [4:0] cnt_nxt;

   // transition-minimizing stage
   always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, data[i]};
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
      q_m_d = '0;
      q_m_d[0] = data[0];
      for (int i = 1; i < 8; i++)
         q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data[i]) : (q_m_d[i-1] ^ data[i]);
      q_m_d[8] = ~use_xnor;
   end

   // DC-balancing stage; disp = n1 - n0 of q_m[7:0] as a 5-bit signed value
   always_comb begin
      n1_q = '0;
      for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b000, q_m_r[i]};
      disp    = {n1_q, 1'b0} - 5'd8;
      sym_nxt = '0;
      cnt_nxt = cnt;
      if (!de_r) begin
         cnt_nxt = '0;
         case ({c1_r, c0_r})
            2'b00:   sym_nxt = 10'b1101010100;
            2'b01:   sym_nxt = 10'b0010101011;
            2'b10:   sym_nxt = 10'b0101010100;
            default: sym_nxt = 10'b1010101011;
         endcase
      end else if ((cnt == 5'd0) || (disp == 5'd0)) begin
         sym_nxt = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
         cnt_nxt = q_m_r[8] ? cnt + disp : cnt - disp;
      end else if (cnt[4] == disp[4]) begin
         // both nonzero here, so equal signs means the running disparity
         // would grow in the same direction: invert the byte
         sym_nxt = {1'b1, q_m_r[8], ~q_m_r[7:0]};
         cnt_nxt = cnt + {3'b000, q_m_r[8], 1'b0} - disp;
      end else begin
         sym_nxt = {1'b0, q_m_r[8], q_m_r[7:0]};
         cnt_nxt = cnt - {3'b000, ~q_m_r[8], 1'b0} + disp;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         valid    <= 1'b0;
         de_r     <= 1'b0;
         c0_r     <= 1'b0;
         c1_r     <= 1'b0;
         q_m_r    <= '0;
         cnt      <= '0;
         symbol   <= '0;
         shreg    <= IDLE_SYMBOL;
         phase    <= '0;
         armed    <= 1'b0;
         misalign <= 1'b0;
      end else if (enable) begin
         // back-to-back loads: stage 2 takes the old stage-1 value this edge
         valid <= load;
         if (load) begin
            de_r  <= data_enable;
            c0_r  <= c0;
            c1_r  <= c1;
            q_m_r <= q_m_d;
         end
         if (valid) begin
            symbol <= sym_nxt;
            cnt    <= cnt_nxt;
            shreg  <= sym_nxt;
            phase  <= '0;
            armed  <= 1'b1;
            if (armed && (phase != 3'd4)) misalign <= 1'b1;
         end else begin
            shreg <= {shreg[1:0], shreg[9:2]};
            phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
         end
      end
   end

   assign tmds_pair = shreg[1:0];

endmodule

// File: tb/tb_ibis_tmds_channel.sv
module tb_ibis_tmds_channel;

   logic       aclk = 1'b0;
   logic       areset;
   logic       enable;
   logic       load;
   logic       data_enable;
   logic       c0;
   logic       c1;
   logic [7:0] data;
   logic [9:0] symbol;
   logic [1:0] tmds_pair;
   logic       misalign;

   int total = 0;
   int bad   = 0;

   int         mcnt = 0;
   int         disp = 0;
   logic       prev_valid = 1'b0;
   logic       prev_de = 1'b0;
   logic [9:0] prev_rec = '0;
   logic [9:0] prev_exp = '0;

   ibis_tmds_channel dut (
      .aclk        (aclk),
      .areset      (areset),
      .enable      (enable),
      .load        (load),
      .data_enable (data_enable),
      .c0          (c0),
      .c1          (c1),
      .data        (data),
      .symbol      (symbol),
      .tmds_pair   (tmds_pair),
      .misalign    (misalign)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference DVI encoder; advances the model disparity mcnt
   function automatic logic [9:0] ref_enc(input logic de, input logic cc1, input logic cc0,
                                          input logic [7:0] d);
      int ones, qo, qz;
      logic inv;
      logic [8:0] qm;
      logic [9:0] s;
      if (!de) begin
         mcnt = 0;
         case ({cc1, cc0})
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
         endcase
         return s;
      end
      ones = $countones(d);
      inv = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ inv;
      qm[8] = !inv;
      qo = $countones(qm[7:0]);
      qz = 8 - qo;
      if (mcnt == 0 || qo == qz) begin
         if (qm[8]) begin
            s = {2'b01, qm[7:0]};
            mcnt = mcnt + qo - qz;
         end else begin
            s = {2'b10, ~qm[7:0]};
            mcnt = mcnt + qz - qo;
         end
      end else if ((mcnt > 0 && qo > qz) || (mcnt < 0 && qz > qo)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         mcnt = mcnt + 2 * int'(qm[8]) + qz - qo;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         mcnt = mcnt - 2 * (1 - int'(qm[8])) + qo - qz;
      end
      return s;
   endfunction

   // called right after the tick that shows bits [9:8] of the previous symbol
   task automatic finish_prev();
      if (prev_valid) begin
         prev_rec[9:8] = tmds_pair;
         chk("pairs_reassembled", {22'd0, prev_rec}, {22'd0, prev_exp});
         if (prev_de) begin
            disp = disp + 2 * $countones(prev_rec) - 10;
            chk("disparity_bound", {31'd0, (disp <= 16 && disp >= -16)}, 32'd1);
         end else begin
            disp = 0;
         end
      end
      prev_valid = 1'b0;
   endtask

   // one 5-cycle pixel slot; freeze_at = k (1..3) drops enable for 7 cycles before tick k+1
   task automatic slot(input logic de, input logic cc1, input logic cc0, input logic [7:0] d,
                       input logic [9:0] exp, input int freeze_at);
      logic [9:0] cur;
      cur = '0;
      data_enable = de; c1 = cc1; c0 = cc0; data = d; load = 1'b1;
      tick();
      finish_prev();
      load = 1'b0;
      tick();
      chk("symbol", {22'd0, symbol}, {22'd0, exp});
      chk("misalign_low", {31'd0, misalign}, 32'd0);
      cur[1:0] = tmds_pair;
      for (int k = 1; k <= 3; k++) begin
         if (freeze_at == k) begin
            enable = 1'b0;
            for (int j = 0; j < 7; j++) begin
               tick();
               chk("freeze_hold", {30'd0, tmds_pair}, {30'd0, exp[2*(k-1) +: 2]});
            end
            enable = 1'b1;
         end
         tick();
         cur[2*k +: 2] = tmds_pair;
      end
      prev_rec = cur; prev_exp = exp; prev_de = de; prev_valid = 1'b1;
   endtask

   initial begin
      logic [1:0] idle_pat [5];
      logic [9:0] e;
      logic [9:0] ea;
      logic [9:0] eb;
      logic [7:0] rd;
      idle_pat[0] = 2'b01; idle_pat[1] = 2'b01; idle_pat[2] = 2'b01;
      idle_pat[3] = 2'b11; idle_pat[4] = 2'b00;

      areset = 1'b1; enable = 1'b0; load = 1'b0; data_enable = 1'b0;
      c0 = 1'b0; c1 = 1'b0; data = '0;
      #1;
      chk("reset_symbol", {22'd0, symbol}, 32'd0);
      chk("reset_pair", {30'd0, tmds_pair}, 32'd0);
      chk("reset_misalign", {31'd0, misalign}, 32'd0);
      #20;
      areset = 1'b0;
      enable = 1'b1;

      // idle rotation
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_pair", {30'd0, tmds_pair}, {30'd0, idle_pat[k % 5]});
         chk("idle_misalign", {31'd0, misalign}, 32'd0);
      end

      // control sweep
      void'(ref_enc(0, 0, 0, 8'h00)); slot(0, 0, 0, 8'h00, 10'h354, 0);
      void'(ref_enc(0, 0, 1, 8'h00)); slot(0, 0, 1, 8'h00, 10'h0AB, 0);
      void'(ref_enc(0, 1, 0, 8'h00)); slot(0, 1, 0, 8'h00, 10'h154, 0);
      void'(ref_enc(0, 1, 1, 8'h00)); slot(0, 1, 1, 8'h00, 10'h2AB, 0);

      // disparity corner cases
      void'(ref_enc(1, 0, 0, 8'h00)); slot(1, 0, 0, 8'h00, 10'h100, 0);
      void'(ref_enc(1, 0, 0, 8'h00)); slot(1, 0, 0, 8'h00, 10'h3FF, 0);
      void'(ref_enc(0, 0, 0, 8'h00)); slot(0, 0, 0, 8'h00, 10'h354, 0);
      void'(ref_enc(1, 0, 0, 8'hFF)); slot(1, 0, 0, 8'hFF, 10'h200, 0);
      void'(ref_enc(0, 0, 0, 8'h00)); slot(0, 0, 0, 8'h00, 10'h354, 0);
      void'(ref_enc(1, 0, 0, 8'h00)); slot(1, 0, 0, 8'h00, 10'h100, 0);

      // steady cadence, random pixels
      for (int n = 0; n < 1000; n++) begin
         rd = 8'($urandom_range(0, 255));
         e = ref_enc(1, 0, 0, rd);
         slot(1, 0, 0, rd, e, 0);
      end

      // enable freeze mid-symbol
      e = ref_enc(1, 0, 0, 8'hA5);
      slot(1, 0, 0, 8'hA5, e, 2);
      e = ref_enc(1, 0, 0, 8'h3C);
      slot(1, 0, 0, 8'h3C, e, 0);

      // early load -> misalign
      data_enable = 1'b1; c0 = 1'b0; c1 = 1'b0;
      data = 8'h5A; load = 1'b1;
      ea = ref_enc(1, 0, 0, 8'h5A);
      tick();
      finish_prev();
      load = 1'b0;
      tick();
      chk("inject_first_symbol", {22'd0, symbol}, {22'd0, ea});
      tick();
      data = 8'hC3; load = 1'b1;
      eb = ref_enc(1, 0, 0, 8'hC3);
      tick();
      chk("misalign_before", {31'd0, misalign}, 32'd0);
      load = 1'b0;
      tick();
      chk("misalign_set", {31'd0, misalign}, 32'd1);
      chk("inject_second_symbol", {22'd0, symbol}, {22'd0, eb});
      for (int k = 0; k < 8; k++) tick();
      chk("misalign_sticky", {31'd0, misalign}, 32'd1);

      // asynchronous reset mid-symbol
      #2;
      areset = 1'b1;
      #1;
      chk("areset_symbol", {22'd0, symbol}, 32'd0);
      chk("areset_pair", {30'd0, tmds_pair}, 32'd0);
      chk("areset_misalign", {31'd0, misalign}, 32'd0);
      #3;
      areset = 1'b0;
      mcnt = 0; disp = 0; prev_valid = 1'b0;
      tick();
      tick();
      void'(ref_enc(0, 1, 0, 8'h00)); slot(0, 1, 0, 8'h00, 10'h154, 0);
      void'(ref_enc(1, 0, 0, 8'h00)); slot(1, 0, 0, 8'h00, 10'h100, 0);
      data_enable = 1'b0;
      tick();
      finish_prev();
      chk("misalign_after_reset", {31'd0, misalign}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
